// File: rtl/airlock_pkg.sv
// Shared types and defaults for the airlock cycle controller slice.
package airlock_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN_REQ,
    S_DRAIN_WAIT,
    S_OUTER_OPEN,
    S_FILL_REQ,
    S_FILL_WAIT,
    S_INNER_OPEN,
    S_FAULT
  } state_e;

  typedef enum logic {
    DIR_ARRIVE = 1'b0,
    DIR_DEPART = 1'b1
  } dir_e;

  localparam int unsigned TIMEOUT_DEF  = 12;
  localparam int unsigned DOOR_CYC_DEF = 4;
  localparam int unsigned CW_DEF       = 4;

endpackage

// File: rtl/airlock_cycle_ctrl_if.sv
// Request/completion inputs and door/countdown outputs of the airlock controller.
interface airlock_cycle_ctrl_if;
  logic arrive_req;
  logic depart_req;
  logic devacuated;
  logic pressurized;
  logic countdown;
  logic outer_open;
  logic inner_open;
  logic busy;
  logic fault;

  modport master (
    output arrive_req, depart_req, devacuated, pressurized,
    input  countdown, outer_open, inner_open, busy, fault
  );

  modport slave (
    input  arrive_req, depart_req, devacuated, pressurized,
    output countdown, outer_open, inner_open, busy, fault
  );
endinterface

// File: rtl/airlock_cycle_timer.sv
// Clear/enable counter with terminal-count compare; saturates instead of wrapping.
module airlock_cycle_timer #(
  parameter int unsigned CW = 4
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          clear,
  input  logic          enable,
  input  logic [CW-1:0] term,
  output logic          tc
);

  logic [CW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)
      cnt_d = '0;
    else if (enable && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge Clock) begin
    if (!Reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tc = (cnt_q == term);

endmodule

// File: rtl/airlock_cycle_ctrl.sv
// Airlock cycle controller: sequences drain/fill countdowns and door holds, latches timeouts.
module airlock_cycle_ctrl
  import airlock_pkg::*;
#(
  parameter int unsigned TIMEOUT  = TIMEOUT_DEF,
  parameter int unsigned DOOR_CYC = DOOR_CYC_DEF,
  parameter int unsigned CW       = CW_DEF
) (
  input  logic                 Clock,
  input  logic                 Reset,
  airlock_cycle_ctrl_if.slave  bus
);

  state_e state_d, state_q;
  dir_e   dir_d, dir_q;
  logic   countdown_d, countdown_q;
  logic   outer_open_d, outer_open_q;
  logic   inner_open_d, inner_open_q;
  logic   busy_d, busy_q;
  logic   fault_d, fault_q;

  logic          in_wait, in_door;
  logic          tmr_clear, tmr_tc;
  logic [CW-1:0] tmr_term;

  // One timer serves both door hold and wait timeout; it restarts on every state change.
  assign in_wait   = (state_q == S_DRAIN_WAIT) || (state_q == S_FILL_WAIT);
  assign in_door   = (state_q == S_OUTER_OPEN) || (state_q == S_INNER_OPEN);
  assign tmr_term  = in_wait ? CW'(TIMEOUT - 1) : CW'(DOOR_CYC - 1);
  assign tmr_clear = (state_d != state_q);

  airlock_cycle_timer #(.CW(CW)) u_timer (
    .Clock  (Clock),
    .Reset  (Reset),
    .clear  (tmr_clear),
    .enable (in_wait || in_door),
    .term   (tmr_term),
    .tc     (tmr_tc)
  );

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    case (state_q)
      S_IDLE: begin
        if (bus.arrive_req) begin
          state_d = S_DRAIN_REQ;
          dir_d   = DIR_ARRIVE;
        end else if (bus.depart_req) begin
          state_d = S_INNER_OPEN;
          dir_d   = DIR_DEPART;
        end
      end
      S_DRAIN_REQ:  state_d = S_DRAIN_WAIT;
      S_FILL_REQ:   state_d = S_FILL_WAIT;
      S_DRAIN_WAIT: begin
        if (bus.devacuated) state_d = S_OUTER_OPEN;
        else if (tmr_tc)    state_d = S_FAULT;
      end
      S_FILL_WAIT: begin
        if (bus.pressurized) state_d = (dir_q == DIR_ARRIVE) ? S_INNER_OPEN : S_IDLE;
        else if (tmr_tc)     state_d = S_FAULT;
      end
      S_OUTER_OPEN: if (tmr_tc) state_d = S_FILL_REQ;
      S_INNER_OPEN: if (tmr_tc) state_d = (dir_q == DIR_ARRIVE) ? S_IDLE : S_DRAIN_REQ;
      S_FAULT:      state_d = S_FAULT;
      default:      state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered copies track state_q.
  always_comb begin
    countdown_d  = (state_d == S_DRAIN_REQ) || (state_d == S_FILL_REQ);
    outer_open_d = (state_d == S_OUTER_OPEN);
    inner_open_d = (state_d == S_INNER_OPEN);
    busy_d       = (state_d != S_IDLE);
    fault_d      = (state_d == S_FAULT);
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q      <= S_IDLE;
      dir_q        <= DIR_ARRIVE;
      countdown_q  <= 1'b0;
      outer_open_q <= 1'b0;
      inner_open_q <= 1'b0;
      busy_q       <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      countdown_q  <= countdown_d;
      outer_open_q <= outer_open_d;
      inner_open_q <= inner_open_d;
      busy_q       <= busy_d;
      fault_q      <= fault_d;
    end
  end

  assign bus.countdown  = countdown_q;
  assign bus.outer_open = outer_open_q;
  assign bus.inner_open = inner_open_q;
  assign bus.busy       = busy_q;
  assign bus.fault      = fault_q;

endmodule

// File: tb/tb_airlock_cycle_ctrl.sv
// Scoreboard bench for airlock_cycle_ctrl paired with a behavioural countdown block.
module tb_airlock_cycle_ctrl;

  logic Clock;
  logic Reset;

  airlock_cycle_ctrl_if bus ();

  airlock_cycle_ctrl #(.TIMEOUT(12), .DOOR_CYC(4), .CW(4)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // {countdown, outer_open, inner_open, busy, fault}
  localparam logic [4:0] E_IDLE = 5'b00000;
  localparam logic [4:0] E_CD   = 5'b10010;
  localparam logic [4:0] E_OUT  = 5'b01010;
  localparam logic [4:0] E_IN   = 5'b00110;
  localparam logic [4:0] E_BUSY = 5'b00010;
  localparam logic [4:0] E_FLT  = 5'b00011;

  // Countdown block model: completes cd_delay cycles after its start pulse, alternating drain/fill.
  int   cd_delay;
  logic stub_en, force_devac, force_press;
  logic [4:0] sc_cnt;
  logic sc_act, sc_kind, sc_phase, sc_done;

  always @(posedge Clock) begin
    if (!Reset) begin
      sc_act <= 1'b0; sc_cnt <= '0; sc_kind <= 1'b0; sc_phase <= 1'b0;
    end else if (bus.countdown) begin
      sc_act   <= 1'b1;
      sc_cnt   <= 5'(cd_delay - 1);
      sc_kind  <= sc_phase;
      sc_phase <= ~sc_phase;
    end else if (sc_act && sc_cnt != 0) begin
      sc_cnt <= sc_cnt - 1'b1;
    end
  end

  assign sc_done         = sc_act && (sc_cnt == 0);
  assign bus.devacuated  = (stub_en && sc_done && !sc_kind) || force_devac;
  assign bus.pressurized = (stub_en && sc_done &&  sc_kind) || force_press;

  typedef struct {
    logic [4:0] v;
    int         t;
    int         c;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int test_id = 0;
  int cyc_n = 0;

  always @(negedge Clock) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [4:0] act;
      e   = q.pop_front();
      act = {bus.countdown, bus.outer_open, bus.inner_open, bus.busy, bus.fault};
      checks++;
      if (act !== e.v) begin
        errors++;
        $display("FAIL outputs test%0d cy%0d: got %b expected %b", e.t, e.c, act, e.v);
      end
      checks++;
      if (bus.outer_open === 1'b1 && bus.inner_open === 1'b1) begin
        errors++;
        $display("FAIL door_overlap test%0d cy%0d: got outer=1 inner=1 expected not both", e.t, e.c);
      end
    end
  end

  task automatic cyc(input logic [4:0] e);
    exp_t x;
    x.v = e; x.t = test_id; x.c = cyc_n;
    q.push_back(x);
    cyc_n++;
    @(posedge Clock);
    #1;
  endtask

  task automatic run(input logic [4:0] e, input int n);
    for (int i = 0; i < n; i++) cyc(e);
  endtask

  task automatic start_test(input int id);
    test_id = id;
    cyc_n   = 0;
  endtask

  // Full arrive sequence from the cycle where arrive_req is first seen in IDLE.
  task automatic arrive_seq();
    bus.arrive_req = 1'b1; cyc(E_IDLE);
    bus.arrive_req = 1'b0; cyc(E_CD);
    run(E_BUSY, 7); run(E_OUT, 4); cyc(E_CD);
    run(E_BUSY, 7); run(E_IN, 4);
  endtask

  task automatic depart_tail();
    run(E_IN, 4); cyc(E_CD);
    run(E_BUSY, 7); run(E_OUT, 4); cyc(E_CD);
    run(E_BUSY, 7);
  endtask

  initial begin
    Reset = 1'b0;
    bus.arrive_req = 1'b0; bus.depart_req = 1'b0;
    stub_en = 1'b1; force_devac = 1'b0; force_press = 1'b0;
    cd_delay = 7;
    @(posedge Clock); #1;

    start_test(0);
    cyc(E_IDLE);
    Reset = 1'b1;
    cyc(E_IDLE);

    start_test(1);
    arrive_seq();
    cyc(E_IDLE);

    start_test(2);
    bus.depart_req = 1'b1; cyc(E_IDLE);
    bus.depart_req = 1'b0; depart_tail();
    cyc(E_IDLE);

    start_test(3);
    bus.arrive_req = 1'b1; bus.depart_req = 1'b1; cyc(E_IDLE);
    bus.arrive_req = 1'b0; cyc(E_CD);
    run(E_BUSY, 7); run(E_OUT, 4); cyc(E_CD);
    run(E_BUSY, 7); run(E_IN, 4);
    cyc(E_IDLE);
    bus.depart_req = 1'b0; depart_tail();
    cyc(E_IDLE);
    run(E_IDLE, 2);

    start_test(4);
    stub_en = 1'b0;
    bus.arrive_req = 1'b1; cyc(E_IDLE);
    bus.arrive_req = 1'b0; cyc(E_CD);
    run(E_BUSY, 12);
    bus.arrive_req = 1'b1; run(E_FLT, 5);
    bus.arrive_req = 1'b0; run(E_FLT, 2);
    Reset = 1'b0; cyc(E_FLT);
    Reset = 1'b1; cyc(E_IDLE);
    stub_en = 1'b1;

    start_test(5);
    bus.arrive_req = 1'b1; cyc(E_IDLE);
    bus.arrive_req = 1'b0; cyc(E_CD);
    run(E_BUSY, 7); run(E_OUT, 2);
    Reset = 1'b0; cyc(E_OUT);
    Reset = 1'b1; cyc(E_IDLE);
    arrive_seq();
    cyc(E_IDLE);

    start_test(6);
    force_devac = 1'b1; force_press = 1'b1; run(E_IDLE, 3);
    force_devac = 1'b0; force_press = 1'b0;
    bus.arrive_req = 1'b1; cyc(E_IDLE);
    bus.arrive_req = 1'b0; cyc(E_CD);
    run(E_BUSY, 7); run(E_OUT, 4); cyc(E_CD);
    force_devac = 1'b1; run(E_BUSY, 7);
    force_devac = 1'b0; run(E_IN, 4);
    cyc(E_IDLE);

    // Completion arriving on the last permitted wait cycle must beat the timeout.
    start_test(7);
    cd_delay = 12;
    bus.arrive_req = 1'b1; cyc(E_IDLE);
    bus.arrive_req = 1'b0; cyc(E_CD);
    run(E_BUSY, 12); run(E_OUT, 4); cyc(E_CD);
    run(E_BUSY, 12); run(E_IN, 4);
    cyc(E_IDLE);
    cd_delay = 7;

    for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge Clock);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
